echo_feedback: RTL

Parametrised multi-channel echo/reverb stage for the audio datapath. It sits between the codec receive interface and the output path, and processes one frame of CHANNELS signed samples per `valid` strobe. It owns its circular delay buffer internally, so no external FIFO is needed. Delay, gain and mode (feed-forward echo or feedback/recirculating echo) are run-time programmable, and every output sample is saturated to the sample range.

---
 rtl/echo_feedback.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/echo_feedback.sv
// Multi-channel echo/reverb stage: feed-forward or recirculating echo over an
// internal circular frame buffer, with per-sample saturation to the sample range.
module echo_feedback #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4096,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      valid,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  input  logic [AW-1:0]             delay,
  input  logic [7:0]                gain,
  input  logic                      feedback,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] audio_out
);

  localparam int FW = CHANNELS * WIDTH;
  localparam int EW = WIDTH + 1;
  localparam int SW = WIDTH + 2;
  localparam int PW = WIDTH + 9;
  localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] FILL_MAX = {AW{1'b1}};

  // Clamp a WIDTH+2 bit sum into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] sat_sample(input logic [SW-1:0] s);
    logic [WIDTH-1:0] r;
    if ((s[SW-1:WIDTH-1] == 3'b000) || (s[SW-1:WIDTH-1] == 3'b111)) begin
      r = s[WIDTH-1:0];
    end else if (s[SW-1]) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  // Delayed sample times g/256, rounded toward minus infinity.
  function automatic logic [EW-1:0] echo_term(input logic [WIDTH-1:0] d, input logic [7:0] g);
    return EW'((PW'($signed(d)) * $signed(PW'({1'b0, g}))) >>> 8);
  endfunction

  logic [FW-1:0]          mem [DEPTH];
  logic [FW-1:0]          rd_data_q;
  logic [FW-1:0]          x_q;
  logic [FW-1:0]          audio_out_q;
  logic [7:0]             gain_q;
  logic                   fb_q;
  logic                   echo_en_q;
  logic [AW-1:0]          rd_addr_q;
  logic [AW-1:0]          wp_q;
  logic [AW-1:0]          fill_q;
  logic [AW-1:0]          fill_d;
  logic [AW-1:0]          prev_delay_q;
  logic                   prev_fb_q;
  logic                   s0_q;
  logic                   s1_q;
  logic                   s2_q;
  logic                   out_valid_q;
  logic signed [EW-1:0]   e_d [CHANNELS];
  logic signed [EW-1:0]   e_q [CHANNELS];
  logic [FW-1:0]          y_s;
  logic [FW-1:0]          wr_data_s;
  logic                   ctrl_chg_s;
  logic [AW-1:0]          fill_eff_s;
  logic                   echo_en_s;

  // Echo gating: a control change restarts the history count for this frame.
  always_comb begin
    ctrl_chg_s = (delay != prev_delay_q) || (feedback != prev_fb_q);
    fill_eff_s = ctrl_chg_s ? {AW{1'b0}} : fill_q;
    echo_en_s  = (delay != {AW{1'b0}}) && (fill_eff_s >= delay);
  end

  // Fill counter next state: clear on control change, count writes, saturate.
  always_comb begin
    fill_d = fill_q;
    if (valid && ctrl_chg_s) begin
      fill_d = {AW{1'b0}};
    end else if (s2_q && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + ONE_A;
    end else begin
      fill_d = fill_q;
    end
  end

  // Per-channel scaled echo term from the delayed frame.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      e_d[c] = echo_en_q ? $signed(echo_term(rd_data_q[c*WIDTH +: WIDTH], gain_q)) : {EW{1'b0}};
    end
  end

  // Per-channel saturated output and the value recirculated into the buffer.
  always_comb begin
    y_s = {FW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      y_s[c*WIDTH +: WIDTH] = sat_sample(SW'($signed(x_q[c*WIDTH +: WIDTH])) + SW'(e_q[c]));
    end
    wr_data_s = fb_q ? y_s : x_q;
  end

  // Delay buffer: synchronous read of the tap, write of the finished frame.
  always_ff @(posedge clock) begin
    if (s2_q) begin
      mem[wp_q] <= wr_data_s;
    end
    if (s0_q) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  // Pipeline, control capture, write pointer and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      x_q          <= {FW{1'b0}};
      audio_out_q  <= {FW{1'b0}};
      gain_q       <= 8'd0;
      fb_q         <= 1'b0;
      echo_en_q    <= 1'b0;
      rd_addr_q    <= {AW{1'b0}};
      wp_q         <= {AW{1'b0}};
      fill_q       <= {AW{1'b0}};
      prev_delay_q <= {AW{1'b0}};
      prev_fb_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        e_q[c] <= {EW{1'b0}};
      end
    end else begin
      s0_q        <= valid;
      s1_q        <= s0_q;
      s2_q        <= s1_q;
      out_valid_q <= s2_q;
      fill_q      <= fill_d;
      if (valid) begin
        x_q          <= audio_in;
        gain_q       <= gain;
        fb_q         <= feedback;
        echo_en_q    <= echo_en_s;
        rd_addr_q    <= wp_q - delay;
        prev_delay_q <= delay;
        prev_fb_q    <= feedback;
      end
      if (s1_q) begin
        for (int c = 0; c < CHANNELS; c++) begin
          e_q[c] <= e_d[c];
        end
      end
      if (s2_q) begin
        audio_out_q <= y_s;
        wp_q        <= wp_q + ONE_A;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign audio_out = audio_out_q;

endmodule
